// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready handshakes.
// Stage 1 holds operands, stage 2 holds the result and its flags.
module logic_unit_pipe #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:WIDTH-1]   X,
   input  logic [0:WIDTH-1]   Y,
   input  logic [2:0]         OP,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:WIDTH-1]   Z,
   output logic               ZF,
   output logic               PF
);

   logic               s1_v_q, s1_v_d;
   logic               s2_v_q, s2_v_d;
   logic [0:WIDTH-1]   x_q, y_q;
   logic [2:0]         op_q;
   logic [0:WIDTH-1]   z_q, z_d;
   logic               zf_q, pf_q;
   logic               s1_load, s1_adv, s2_load;

   // An empty stage 2 or a draining result frees room for stage 1
   assign s2_load  = !s2_v_q || out_ready;
   assign s1_adv   = s1_v_q && s2_load;
   assign in_ready = !s1_v_q || s1_adv;
   assign s1_load  = in_valid && in_ready;

   assign s1_v_d = s1_load || (s1_v_q && !s1_adv);
   assign s2_v_d = s1_adv || (s2_v_q && !out_ready);

   always_comb begin
      z_d = '0;
      unique case (op_q)
         3'b000: z_d = x_q & y_q;
         3'b001: z_d = x_q | y_q;
         3'b010: z_d = x_q ^ y_q;
         3'b011: z_d = ~(x_q & y_q);
         3'b100: z_d = ~(x_q | y_q);
         3'b101: z_d = ~(x_q ^ y_q);
         3'b110: z_d = x_q & ~y_q;
         3'b111: z_d = x_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         x_q    <= '0;
         y_q    <= '0;
         op_q   <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         if (s1_load) begin
            x_q  <= X;
            y_q  <= Y;
            op_q <= OP;
         end
      end
   end

   // Result registers change only on an advance, so they hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_v_q <= 1'b0;
         z_q    <= '0;
         zf_q   <= 1'b1;
         pf_q   <= 1'b0;
      end else begin
         s2_v_q <= s2_v_d;
         if (s1_adv) begin
            z_q  <= z_d;
            zf_q <= ~|z_d;
            pf_q <= ^z_d;
         end
      end
   end

   assign out_valid = s2_v_q;
   assign Z         = z_q;
   assign ZF        = zf_q;
   assign PF        = pf_q;

endmodule
